// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared state encoding and default constants for the pipeline run controller.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    // Controller states. The numeric values are fixed so that debug tools
    // reading the raw state see a stable encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Cycles spent draining after HALT is accepted in ID: HALT travels
    // ID -> EX -> MEM -> WB while older instructions retire.
    localparam int DRAIN_CYCLES_DEF = 4;

    // Default width of the active-cycle counter.
    localparam int NB_CNT_DEF = 32;

    // The pipeline advances only in these states; IDLE and HALTED freeze it.
    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Purpose: bundle of hazard/debug requests and per-stage enable/flush strobes.
// Latency: n/a (wires only).
// Backpressure: n/a; i_stall from the hazard unit is the only hold request.
//
// master: hazard unit + debug unit side (drives requests, observes strobes).
// slave : pipeline_ctrl side (consumes requests, drives strobes and status).
interface pipeline_ctrl_if #(
    parameter int NB_CNT = 32
);
    // Requests from the hazard unit, decode stage and debug unit.
    logic              i_stall;
    logic              i_flush_idex;
    logic              i_redirect;
    logic              i_halt_id;
    logic              i_dbg_run;
    logic              i_dbg_stop;
    logic              i_dbg_step;

    // Per-stage strobes and run status.
    logic              o_pc_en;
    logic              o_ifid_en;
    logic              o_ifid_flush;
    logic              o_idex_en;
    logic              o_idex_flush;
    logic              o_exmem_en;
    logic              o_memwb_en;
    logic              o_running;
    logic              o_step_done;
    logic              o_halted;
    logic [NB_CNT-1:0] o_cycle_cnt;

    modport master (
        output i_stall, i_flush_idex, i_redirect, i_halt_id,
               i_dbg_run, i_dbg_stop, i_dbg_step,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
               o_exmem_en, o_memwb_en, o_running, o_step_done, o_halted,
               o_cycle_cnt
    );

    modport slave (
        input  i_stall, i_flush_idex, i_redirect, i_halt_id,
               i_dbg_run, i_dbg_stop, i_dbg_step,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
               o_exmem_en, o_memwb_en, o_running, o_step_done, o_halted,
               o_cycle_cnt
    );

endinterface

// File: rtl/pipe_cycle_counter.sv
// Purpose: NB_CNT-wide enable counter with synchronous reset; wraps silently.
// Latency: count updates on the edge after en is sampled high.
// Backpressure: none; holds its value while en is low.
//
// Ports: clk, rst (sync, active-high), en (count this cycle), cnt (value).
module pipe_cycle_counter #(
    parameter int NB_CNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [NB_CNT-1:0] cnt
);

    localparam logic [NB_CNT-1:0] ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: turns hazard stall/flush and redirect requests into per-stage enables and flushes,
//          and owns debug run control (run, single-step, orderly drain on HALT).
// Latency: strobes are combinational from state+inputs; state and status update on the next edge.
// Backpressure: i_stall holds PC and IF/ID (and defers HALT acceptance); later stages keep flowing.
//
// Ports: i_clk, i_rst (sync, active-high); bus (pipeline_ctrl_if.slave) carries all
//        requests, stage strobes, run status and the active-cycle count.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int NB_CNT       = NB_CNT_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pipeline_ctrl_if.slave bus
);

    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0]  DRAIN_DEC  = DW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_cnt_nxt;
    logic          step_done;
    logic          active;
    logic          in_drain;
    logic          halt_ok;

    assign active   = is_active(state);
    assign in_drain = (state == ST_DRAIN);
    // HALT under a stall is held off: the instruction has not really left ID yet.
    assign halt_ok  = bus.i_halt_id & ~bus.i_stall;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            step_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            // Pulses after every STEP cycle, including one that turned into a drain.
            step_done <= (state == ST_STEP);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;

        case (state)
            ST_IDLE: begin
                // Run wins over step when both are requested together.
                if (bus.i_dbg_run) begin
                    state_nxt = ST_RUN;
                end else if (bus.i_dbg_step) begin
                    state_nxt = ST_STEP;
                end
            end

            ST_RUN: begin
                // Accepting HALT takes priority over a stop in the same cycle.
                if (halt_ok) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end else if (bus.i_dbg_stop) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_STEP: begin
                // A step that accepts HALT drains on its own instead of returning.
                if (halt_ok) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Debug and HALT requests are ignored until the drain completes.
                if (drain_cnt == '0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - DRAIN_DEC;
                end
            end

            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end

            default: begin
                // Unused encodings fall back to a frozen pipeline.
                state_nxt     = ST_IDLE;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage strobes
    // ------------------------------------------------------------------
    // Back half of the pipe always flows while active so a stalled
    // instruction's producers can still complete.
    assign bus.o_idex_en    = active;
    assign bus.o_exmem_en   = active;
    assign bus.o_memwb_en   = active;
    // Drain injects bubbles behind HALT so nothing younger executes.
    assign bus.o_idex_flush = active & (bus.i_flush_idex | in_drain);
    assign bus.o_ifid_en    = active & ~bus.i_stall;
    // Stall beats redirect: branch operands are not valid while stalled.
    assign bus.o_ifid_flush = active & ~bus.i_stall & (bus.i_redirect | in_drain);
    // Redirect keeps PC enabled so the new target loads; drain freezes fetch.
    assign bus.o_pc_en      = active & ~bus.i_stall & ~in_drain;

    assign bus.o_running    = (state == ST_RUN);
    assign bus.o_halted     = (state == ST_HALTED);
    assign bus.o_step_done  = step_done;

    // ------------------------------------------------------------------
    // Active-cycle counter
    // ------------------------------------------------------------------
    pipe_cycle_counter #(
        .NB_CNT (NB_CNT)
    ) u_cycle_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .en  (active),
        .cnt (bus.o_cycle_cnt)
    );

endmodule
